// File: rtl/uart_alu_sequencer.sv
// Sequencer between rx_uart, alu_mod and tx_uart: collects operand1/operand2/opcode,
// latches the ALU result, starts one transmit, and flags timeouts and overruns.
module uart_alu_sequencer #(
  parameter int DATA_BITS      = 8,
  parameter int OPCODE_BITS    = 6,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_rx_data_ready,
  input  logic [DATA_BITS-1:0]   i_rx_data,
  input  logic [DATA_BITS-1:0]   i_alu_result,
  input  logic                   i_tx_available,
  output logic [DATA_BITS-1:0]   o_operando1,
  output logic [DATA_BITS-1:0]   o_operando2,
  output logic [OPCODE_BITS-1:0] o_opcode,
  output logic                   o_start_tx,
  output logic [DATA_BITS-1:0]   o_tx_data,
  output logic                   o_error,
  output logic [11:0]            o_led
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_OP2 = 3'd1;
  localparam logic [2:0] S_WAIT_OPC = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_WAIT_TX  = 3'd4;
  localparam logic [2:0] S_SENDING  = 3'd5;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   prev_ready_q, prev_ready_d;
  logic [DATA_BITS-1:0]   op1_q, op1_d, op2_q, op2_d, tx_q, tx_d;
  logic [OPCODE_BITS-1:0] opc_q, opc_d;
  logic                   start_q, start_d, err_q, err_d;
  logic                   rx_pulse_s, timeout_s, counting_s;
  logic [7:0]             led_byte_s;

  assign rx_pulse_s = i_rx_data_ready & ~prev_ready_q;
  assign timeout_s  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign counting_s = (state_q == S_WAIT_OP2) || (state_q == S_WAIT_OPC) || (state_q == S_SENDING);

  // State, timeout counter and strobe edge-detect registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      prev_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_ready_q <= prev_ready_d;
    end
  end

  // Next-state and timeout counter logic
  always_comb begin
    state_d      = state_q;
    prev_ready_d = i_rx_data_ready;
    case (state_q)
      S_IDLE:     if (rx_pulse_s) state_d = S_WAIT_OP2; else state_d = S_IDLE;
      S_WAIT_OP2: if (rx_pulse_s) state_d = S_WAIT_OPC; else if (timeout_s) state_d = S_IDLE;
                  else state_d = S_WAIT_OP2;
      S_WAIT_OPC: if (rx_pulse_s) state_d = S_EXEC; else if (timeout_s) state_d = S_IDLE;
                  else state_d = S_WAIT_OPC;
      S_EXEC:     state_d = S_WAIT_TX;
      S_WAIT_TX:  if (i_tx_available) state_d = S_SENDING; else state_d = S_WAIT_TX;
      // A dropped tx_available means the transmitter took the byte
      S_SENDING:  if (!i_tx_available || timeout_s) state_d = S_IDLE; else state_d = S_SENDING;
      default:    state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Output register next values
  always_comb begin
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    tx_d    = tx_q;
    err_d   = err_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_pulse_s) begin
          op1_d = i_rx_data;
          err_d = 1'b0;
        end else begin
          op1_d = op1_q;
        end
      end
      S_WAIT_OP2: begin
        if (rx_pulse_s) op2_d = i_rx_data; else if (timeout_s) err_d = 1'b1; else err_d = err_q;
      end
      S_WAIT_OPC: begin
        if (rx_pulse_s) opc_d = i_rx_data[OPCODE_BITS-1:0]; else if (timeout_s) err_d = 1'b1;
        else err_d = err_q;
      end
      S_EXEC: begin
        tx_d = i_alu_result;
        if (rx_pulse_s) err_d = 1'b1; else err_d = err_q;
      end
      S_WAIT_TX: begin
        if (rx_pulse_s) err_d = 1'b1; else err_d = err_q;
        if (i_tx_available) start_d = 1'b1; else start_d = 1'b0;
      end
      S_SENDING: begin
        if (rx_pulse_s || (i_tx_available && timeout_s)) err_d = 1'b1; else err_d = err_q;
      end
      default: begin
        start_d = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      tx_q    <= tx_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  generate
    if (DATA_BITS >= 8) begin : g_led_trunc
      assign led_byte_s = tx_q[7:0];
    end else begin : g_led_ext
      assign led_byte_s = {{(8-DATA_BITS){1'b0}}, tx_q};
    end
  endgenerate

  assign o_operando1 = op1_q;
  assign o_operando2 = op2_q;
  assign o_opcode    = opc_q;
  assign o_start_tx  = start_q;
  assign o_tx_data   = tx_q;
  assign o_error     = err_q;
  assign o_led       = {err_q, state_q, led_byte_s};

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer: a transaction-level model is stepped every clock
// and compared against all outputs, plus hand-computed literal checks per scenario.
module tb_uart_alu_sequencer;
  localparam int T = 64;

  logic       clk = 1'b0, rst_n = 1'b0, rdy = 1'b0, avail = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic [7:0] alu_res, op1, op2, txd;
  logic [5:0] opc;
  logic       start, err;
  logic [11:0] led;

  uart_alu_sequencer #(.DATA_BITS(8), .OPCODE_BITS(6), .TIMEOUT_CYCLES(T)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data_ready(rdy), .i_rx_data(rxd),
    .i_alu_result(alu_res), .i_tx_available(avail),
    .o_operando1(op1), .o_operando2(op2), .o_opcode(opc), .o_start_tx(start),
    .o_tx_data(txd), .o_error(err), .o_led(led));

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] o);
    if (o == 6'h20) return a + b;
    else if (o == 6'h22) return a - b;
    else return 8'h00;
  endfunction

  assign alu_res = alu_f(op1, op2, opc);

  int errors = 0, checks = 0, starts = 0;

  // Model: phase 0 idle, 1/2 waiting for byte 2/3, 3 exec, 4 waiting tx, 5 sending
  logic [2:0] m_st;
  logic [7:0] m_op1, m_op2, m_tx;
  logic [5:0] m_opc;
  logic       m_start, m_err, m_prev;
  int         m_age;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 3'd0; m_op1 = 8'h00; m_op2 = 8'h00; m_tx = 8'h00; m_opc = 6'h00;
    m_start = 1'b0; m_err = 1'b0; m_prev = 1'b0; m_age = 0;
  endtask

  task automatic model_step();
    logic pulse;
    logic [2:0] nst;
    logic expired;
    pulse = rdy && !m_prev;
    m_prev = rdy;
    nst = m_st;
    expired = (m_age == T - 1);
    m_start = 1'b0;
    case (m_st)
      3'd0: if (pulse) begin m_op1 = rxd; m_err = 1'b0; nst = 3'd1; end
      3'd1: if (pulse) begin m_op2 = rxd; nst = 3'd2; end
            else if (expired) begin m_err = 1'b1; nst = 3'd0; end
      3'd2: if (pulse) begin m_opc = rxd[5:0]; nst = 3'd3; end
            else if (expired) begin m_err = 1'b1; nst = 3'd0; end
      3'd3: begin m_tx = alu_f(m_op1, m_op2, m_opc); if (pulse) m_err = 1'b1; nst = 3'd4; end
      3'd4: begin if (pulse) m_err = 1'b1; if (avail) begin m_start = 1'b1; nst = 3'd5; end end
      3'd5: begin
        if (pulse) m_err = 1'b1;
        if (!avail) nst = 3'd0;
        else if (expired) begin m_err = 1'b1; nst = 3'd0; end
      end
      default: nst = 3'd0;
    endcase
    if (nst != m_st) m_age = 0;
    else if (m_st == 3'd1 || m_st == 3'd2 || m_st == 3'd5) m_age = m_age + 1;
    else m_age = 0;
    m_st = nst;
  endtask

  task automatic compare_all();
    chk("operando1", op1, m_op1);
    chk("operando2", op2, m_op2);
    chk("opcode", opc, m_opc);
    chk("start_tx", start, m_start);
    chk("tx_data", txd, m_tx);
    chk("error", err, m_err);
    chk("led", led, {m_err, m_st, m_tx});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    compare_all();
    if (start) starts++;
  endtask

  task automatic send_byte(logic [7:0] b, int hold);
    rxd = b;
    rdy = 1'b1;
    repeat (hold) tick();
    rdy = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    // 1: reset and quiet idle
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_led", led, 12'h000);
    chk("idle_start", start, 1'b0);

    // 2: 5 + 3 with tx free; start in the cycle after edge E+2
    avail = 1'b1;
    send_byte(8'h05, 1);
    send_byte(8'h03, 1);
    rxd = 8'h20; rdy = 1'b1;
    tick();                           // edge E
    chk("exec_state", led[10:8], 3'd3);
    rdy = 1'b0;
    tick();                           // E+1
    chk("no_early_start", start, 1'b0);
    tick();                           // E+2
    chk("add_start", start, 1'b1);
    chk("add_led", led, 12'h508);
    chk("add_tx", txd, 8'h08);
    avail = 1'b0;
    tick();
    chk("back_idle", led[10:8], 3'd0);
    avail = 1'b1;

    // 3: inter-byte timeout, then recovery
    send_byte(8'h11, 1);
    repeat (70) tick();
    chk("timeout_err", led[11], 1'b1);
    chk("timeout_state", led[10:8], 3'd0);
    chk("timeout_starts", starts, 1);
    send_byte(8'h07, 1);
    chk("clear_err", err, 1'b0);
    chk("new_op1", op1, 8'h07);
    // byte arriving on the last allowed cycle wins over the timeout
    repeat (T - 2) tick();
    send_byte(8'h02, 1);
    chk("edge_no_err", err, 1'b0);
    chk("edge_state", led[10:8], 3'd2);
    send_byte(8'h20, 1);
    tick();
    chk("edge_tx", txd, 8'h09);
    avail = 1'b0;
    tick();

    // 4: transmitter busy for a long time
    send_byte(8'h09, 1);
    send_byte(8'h04, 1);
    send_byte(8'h22, 1);
    repeat (100) tick();
    chk("busy_state", led[10:8], 3'd4);
    chk("busy_starts", starts, 2);
    avail = 1'b1;
    tick();
    chk("sub_start", start, 1'b1);
    chk("sub_tx", txd, 8'h05);
    avail = 1'b0;
    tick();

    // 5: overrun during WAIT_TX
    send_byte(8'h0C, 1);
    send_byte(8'h0A, 1);
    send_byte(8'h20, 1);
    send_byte(8'hAA, 1);
    chk("ovr_err", err, 1'b1);
    chk("ovr_op1", op1, 8'h0C);
    chk("ovr_op2", op2, 8'h0A);
    chk("ovr_tx", txd, 8'h16);
    avail = 1'b1;
    tick();
    chk("ovr_start", start, 1'b1);
    avail = 1'b0;
    tick();
    chk("ovr_err_sticky", err, 1'b1);
    avail = 1'b1;

    // 6: held strobe counts once; reset mid-operation
    send_byte(8'h33, 10);
    chk("hold_op1", op1, 8'h33);
    chk("hold_state", led[10:8], 3'd1);
    send_byte(8'h44, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_led", led, 12'h000);
    chk("rst_op2", op2, 8'h00);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    send_byte(8'h55, 1);
    chk("post_rst_op1", op1, 8'h55);
    chk("post_rst_state", led[10:8], 3'd1);
    chk("total_starts", starts, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
